// File: rtl/alu_8bit.sv
// alu_8bit: registered WIDTH-bit ALU with carry, zero and signed-overflow flags.
// Define ALU_EXT_OPS_EN to enable opcodes 1000-1111; otherwise they return zero.
module alu_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] Y,
    output logic             carry_out,
    output logic             zero,
    output logic             overflow
);
    localparam int M = WIDTH - 1;
    logic [WIDTH-1:0] y_d;
    logic             c_d;
    logic             v_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    assign sum = {1'b0, A} + {1'b0, B};
    // the extra top bit of the widened difference is the unsigned borrow
    assign dif = {1'b0, A} - {1'b0, B};
    always_comb begin
        y_d = '0;
        c_d = 1'b0;
        v_d = 1'b0;
        case (sel)
            4'h0: begin
                {c_d, y_d} = sum;
                v_d = (A[M] == B[M]) && (sum[M] != A[M]);
            end
            4'h1: begin
                {c_d, y_d} = dif;
                v_d = (A[M] != B[M]) && (dif[M] != A[M]);
            end
            4'h2: y_d = A & B;
            4'h3: y_d = A | B;
            4'h4: y_d = A ^ B;
            4'h5: y_d = ~A;
            4'h6: begin
                y_d = {A[M-1:0], 1'b0};
                c_d = A[M];
            end
            4'h7: begin
                y_d = {1'b0, A[M:1]};
                c_d = A[0];
            end
`ifdef ALU_EXT_OPS_EN
            4'h8: begin
                y_d = {A[M-1:0], A[M]};
                c_d = A[M];
            end
            4'h9: begin
                y_d = {A[0], A[M:1]};
                c_d = A[0];
            end
            4'hA: begin
                {c_d, y_d} = {1'b0, A} + (WIDTH+1)'(1);
                v_d = A == {1'b0, {M{1'b1}}};
            end
            4'hB: begin
                y_d = A - WIDTH'(1);
                c_d = A == '0;
                v_d = A == {1'b1, {M{1'b0}}};
            end
            4'hC: begin
                y_d = {A[M], A[M:1]};
                c_d = A[0];
            end
            4'hD: y_d = A;
            4'hE: y_d = B;
            4'hF: y_d = {{M{1'b0}}, $signed(A) < $signed(B)};
`endif
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Y         <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
        end else begin
            Y         <= y_d;
            carry_out <= c_d;
            overflow  <= v_d;
            zero      <= y_d == '0;
        end
    end
endmodule

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit: directed and randomized checks of alu_8bit against an integer reference model.
module tb_alu_8bit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic [3:0] sel = '0;
    logic [7:0] Y;
    logic       carry_out;
    logic       zero;
    logic       overflow;
    int         n_vec = 0;
    int         n_bad = 0;
    int         edge_v[5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

    alu_8bit dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .sel(sel),
        .Y(Y), .carry_out(carry_out), .zero(zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int y, input int c, input int z, input int v);
        chk({tag, ".Y"}, Y, 8'(y));
        chk({tag, ".carry"}, {7'b0, carry_out}, 8'(c));
        chk({tag, ".zero"}, {7'b0, zero}, 8'(z));
        chk({tag, ".ovf"}, {7'b0, overflow}, 8'(v));
    endtask

    task automatic op(input int a, input int b, input int s);
        A = 8'(a);
        B = 8'(b);
        sel = 4'(s);
        @(posedge clk);
        #1;
        n_vec++;
    endtask

    function automatic int sgn(input int x);
        return x > 127 ? x - 256 : x;
    endfunction

    function automatic void model(input int a, input int b, input int s,
                                  output int y, output int c, output int v);
        int sa = sgn(a);
        int sb = sgn(b);
        int r = 0;
        c = 0;
        v = 0;
        case (s)
            0: begin r = a + b; c = int'(r > 255); v = int'(sa + sb > 127 || sa + sb < -128); end
            1: begin r = a - b + 256; c = int'(a < b); v = int'(sa - sb > 127 || sa - sb < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: begin r = a * 2; c = a / 128; end
            7: begin r = a / 2; c = a % 2; end
`ifdef ALU_EXT_OPS_EN
            8: begin r = a * 2 + a / 128; c = a / 128; end
            9: begin r = a / 2 + (a % 2) * 128; c = a % 2; end
            10: begin r = a + 1; c = int'(a == 255); v = int'(sa == 127); end
            11: begin r = a + 255; c = int'(a == 0); v = int'(sa == -128); end
            12: begin r = a / 2 + (a >= 128 ? 128 : 0); c = a % 2; end
            13: r = a;
            14: r = b;
            15: r = int'(sa < sb);
`endif
            default: r = 0;
        endcase
        y = r % 256;
    endfunction

    task automatic op_model(input string tag, input int a, input int b, input int s);
        int y, c, v;
        op(a, b, s);
        model(a, b, s, y, c, v);
        expect_out($sformatf("%s a=%h b=%h sel=%0d", tag, a, b, s), y, c, int'(y == 0), v);
    endtask

    initial begin
        op(8'h12, 8'h34, 0);
        expect_out("reset", 0, 0, 1, 0);
        rst_n = 1'b1;
        op(8'h12, 8'h34, 0);  expect_out("add", 8'h46, 0, 0, 0);
        op(8'h80, 8'h80, 0);  expect_out("add_ovf", 8'h00, 1, 1, 1);
        op(8'h55, 8'h11, 1);  expect_out("sub", 8'h44, 0, 0, 0);
        op(8'h00, 8'h01, 1);  expect_out("sub_borrow", 8'hFF, 1, 0, 0);
        op(8'h80, 8'h01, 1);  expect_out("sub_ovf", 8'h7F, 0, 0, 1);
        op(8'hF0, 8'h0F, 2);  expect_out("and", 8'h00, 0, 1, 0);
        op(8'hF0, 8'h0F, 3);  expect_out("or", 8'hFF, 0, 0, 0);
        op(8'hAA, 8'hFF, 4);  expect_out("xor", 8'h55, 0, 0, 0);
        op(8'h0F, 8'hFF, 5);  expect_out("not", 8'hF0, 0, 0, 0);
        op(8'h03, 8'h00, 6);  expect_out("shl", 8'h06, 0, 0, 0);
        op(8'h80, 8'h00, 7);  expect_out("shr", 8'h40, 0, 0, 0);
        op(8'h81, 8'h00, 6);  expect_out("shl_carry", 8'h02, 1, 0, 0);
        op(8'h12, 8'h34, 0);
        A = 8'h80;
        B = 8'h80;
        #2 rst_n = 1'b0;
        #1 expect_out("rst_no_async", 8'h46, 0, 0, 0);
        @(posedge clk);
        #1 expect_out("rst_mid", 0, 0, 1, 0);
        n_vec++;
        rst_n = 1'b1;
        @(posedge clk);
        #1 expect_out("rst_release", 8'h00, 1, 1, 1);
        n_vec++;
        op(8'h12, 8'h34, 0);
`ifdef ALU_EXT_OPS_EN
        op(8'h81, 8'h00, 8);  expect_out("rol", 8'h03, 1, 0, 0);
        op(8'h7F, 8'h00, 10); expect_out("inc_ovf", 8'h80, 0, 0, 1);
`else
        op(8'h7F, 8'h00, 10); expect_out("ext_off", 8'h00, 0, 1, 0);
`endif
        for (int s = 0; s < 16; s++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    op_model("edge", edge_v[i], edge_v[j], s);
        for (int k = 0; k < 400; k++)
            op_model("rand", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 15)));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
